// File: rtl/puc_sequencer_pkg.sv
// rtl/puc_sequencer_pkg.sv - shared widths, opcodes and state encodings for the PUC sequencer
package puc_sequencer_pkg;

  localparam int OPCODE_WIDTH      = 4;
  localparam int REGISTER_WIDTH    = 8;
  localparam int PC_WIDTH          = 8;
  localparam int INSTRUCTION_WIDTH = 16;

  localparam logic [OPCODE_WIDTH-1:0] LOAD0       = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] JUMP1       = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] ADD2        = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] JUMPZERO3   = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] HALT4       = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OR6         = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] LOADSWITCH7 = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] AND8        = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] INCREMENT11 = 4'd11;
  localparam logic [OPCODE_WIDTH-1:0] LSHIFT13    = 4'd13;
  localparam logic [OPCODE_WIDTH-1:0] DECREMENT14 = 4'd14;
  localparam logic [OPCODE_WIDTH-1:0] RSHIFT15    = 4'd15;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;

  // Opcodes whose ALU result is written back to the register file
  function automatic logic is_alu_op(logic [OPCODE_WIDTH-1:0] op);
    case (op)
      LOAD0, ADD2, OR6, LOADSWITCH7, AND8,
      INCREMENT11, LSHIFT13, DECREMENT14, RSHIFT15: is_alu_op = 1'b1;
      default:                                      is_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/puc_sequencer_if.sv
// rtl/puc_sequencer_if.sv - program memory and ALU bus between sequencer and datapath
interface puc_sequencer_if;
  import puc_sequencer_pkg::*;

  logic [PC_WIDTH-1:0]          programAddress;
  logic                         programReadEnable;
  logic [INSTRUCTION_WIDTH-1:0] programData;
  logic [OPCODE_WIDTH-1:0]      opCode;
  logic [REGISTER_WIDTH-1:0]    register1Value;
  logic [REGISTER_WIDTH-1:0]    register2Value;
  logic [REGISTER_WIDTH-1:0]    instructionValue;
  logic [REGISTER_WIDTH-1:0]    aluResult;

  modport master (
    output programAddress, programReadEnable, opCode,
           register1Value, register2Value, instructionValue,
    input  programData, aluResult
  );

  modport slave (
    input  programAddress, programReadEnable, opCode,
           register1Value, register2Value, instructionValue,
    output programData, aluResult
  );

endinterface

// File: rtl/puc_sequencer_register_file.sv
// rtl/puc_sequencer_register_file.sv - 4-entry register file, two async reads, one sync write
module register_file
  import puc_sequencer_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                read_addr1,
  input  logic [1:0]                read_addr2,
  output logic [REGISTER_WIDTH-1:0] read_data1,
  output logic [REGISTER_WIDTH-1:0] read_data2,
  input  logic                      write_enable,
  input  logic [1:0]                write_addr,
  input  logic [REGISTER_WIDTH-1:0] write_data,
  output logic [REGISTER_WIDTH-1:0] reg0
);

  logic [REGISTER_WIDTH-1:0] regs [4];

  // Reset clears all entries and wins over a same-cycle write
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (write_enable) begin
      regs[write_addr] <= write_data;
    end
  end

  // Reads see the pre-write value, so dest==src needs no forwarding
  assign read_data1 = regs[read_addr1];
  assign read_data2 = regs[read_addr2];
  assign reg0       = regs[0];

endmodule

// File: rtl/puc_sequencer.sv
// rtl/puc_sequencer.sv - fetch/decode/execute controller for the 8-bit PUC CPU
module puc_sequencer
  import puc_sequencer_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      hold,
  puc_sequencer_if.master           bus,
  output logic [PC_WIDTH-1:0]       programCounter,
  output logic [REGISTER_WIDTH-1:0] outputValue,
  output logic                      halted
);

  state_t                       state, state_next;
  logic [PC_WIDTH-1:0]          pc, pc_next, pc_inc;
  logic [INSTRUCTION_WIDTH-1:0] ir;
  logic                         zero_flag, zero_next;
  logic                         rf_write, read_strobe;
  logic [OPCODE_WIDTH-1:0]      op;
  logic [REGISTER_WIDTH-1:0]    imm;

  assign op     = ir[15:12];
  assign imm    = ir[7:0];
  assign pc_inc = pc + PC_WIDTH'(1);

  // State, PC, flag and instruction register; instruction latched while in DECODE
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      zero_flag <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      zero_flag <= zero_next;
      if (state == DECODE) ir <= bus.programData;
    end
  end

  // Next-state, PC update, writeback and read strobe decisions
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    zero_next   = zero_flag;
    rf_write    = 1'b0;
    read_strobe = 1'b0;
    case (state)
      FETCH: begin
        if (!hold) begin
          read_strobe = 1'b1;
          state_next  = DECODE;
        end
      end
      DECODE: state_next = EXECUTE;
      EXECUTE: begin
        state_next = FETCH;
        pc_next    = pc_inc;
        if (is_alu_op(op)) begin
          rf_write  = 1'b1;
          zero_next = (bus.aluResult == '0);
        end else if (op == JUMP1) begin
          pc_next = imm;
        end else if (op == JUMPZERO3) begin
          pc_next = zero_flag ? imm : pc_inc;
        end else if (op == HALT4) begin
          pc_next    = pc;
          state_next = HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  register_file u_register_file (
    .clock       (clock),
    .reset       (reset),
    .read_addr1  (ir[9:8]),
    .read_addr2  (ir[7:6]),
    .read_data1  (bus.register1Value),
    .read_data2  (bus.register2Value),
    .write_enable(rf_write & ~reset),
    .write_addr  (ir[11:10]),
    .write_data  (bus.aluResult),
    .reg0        (outputValue)
  );

  assign bus.programAddress    = pc;
  assign bus.programReadEnable = read_strobe & ~reset;
  assign bus.opCode            = op;
  assign bus.instructionValue  = imm;
  assign programCounter        = pc;
  assign halted                = (state == HALT);

endmodule

// File: tb/tb_puc_sequencer.sv
// tb/tb_puc_sequencer.sv - scoreboard bench for puc_sequencer with memory and ALU models
module tb_puc_sequencer;
  import puc_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hold  = 1'b0;
  logic [7:0] programCounter, outputValue;
  logic       halted;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [15:0] mem [256];

  typedef struct {int c; logic [7:0] pc; logic [7:0] out;} fetch_t;
  fetch_t exp_q[$];
  fetch_t mon_e;

  puc_sequencer_if bus();

  puc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .hold          (hold),
    .bus           (bus),
    .programCounter(programCounter),
    .outputValue   (outputValue),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  // Synchronous-read program memory
  always @(posedge clock) if (bus.programReadEnable) bus.programData <= mem[bus.programAddress];

  // Reference ALU
  always_comb begin
    bus.aluResult = 8'hEE;
    case (bus.opCode)
      4'd0:  bus.aluResult = bus.instructionValue;
      4'd2:  bus.aluResult = bus.register1Value + bus.register2Value;
      4'd6:  bus.aluResult = bus.register1Value | bus.register2Value;
      4'd7:  bus.aluResult = 8'h5A;
      4'd8:  bus.aluResult = bus.register1Value & bus.register2Value;
      4'd11: bus.aluResult = bus.register1Value + 8'd1;
      4'd13: bus.aluResult = bus.register1Value << 1;
      4'd14: bus.aluResult = bus.register1Value - 8'd1;
      4'd15: bus.aluResult = bus.register1Value >> 1;
      default: bus.aluResult = 8'hEE;
    endcase
  end

  // Cycle index since last reset release
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  // Monitor: every fetch strobe is matched against the next expected fetch
  always @(negedge clock) begin
    if (!reset && bus.programReadEnable) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL fetch_unexpected: cycle %0d pc %0h", cyc, bus.programAddress);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.c || bus.programAddress !== mon_e.pc || outputValue !== mon_e.out) begin
          miscompares++;
          $display("FAIL fetch: got cycle %0d pc %0h out %0h, expected cycle %0d pc %0h out %0h",
                   cyc, bus.programAddress, outputValue, mon_e.c, mon_e.pc, mon_e.out);
        end
      end
    end
  end

  function automatic logic [15:0] enc(logic [3:0] op, logic [1:0] d, logic [1:0] s1, logic [7:0] lo);
    return {op, d, s1, lo};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_fetch(int c, logic [7:0] p, logic [7:0] o);
    exp_q.push_back('{c, p, o});
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000;
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic start_cycle(int k);
    while (cyc < k) begin @(posedge clock); #1; end
  endtask

  task automatic in_cycle(int k);
    start_cycle(k);
    @(negedge clock);
  endtask

  initial begin
    assert_reset();
    @(negedge clock);
    chk("reset_pc", programCounter, 8'h00);
    chk("reset_out", outputValue, 8'h00);
    chk("reset_halted", halted, 1'b0);
    chk("reset_rden", bus.programReadEnable, 1'b0);
    chk("reset_opcode", bus.opCode, 4'h0);

    // Program: LOAD0 r1,#5; LOAD0 r2,#3; ADD2 r0,r1,r2; HALT4
    mem[0] = enc(4'd0, 2'd1, 2'd0, 8'd5);
    mem[1] = enc(4'd0, 2'd2, 2'd0, 8'd3);
    mem[2] = enc(4'd2, 2'd0, 2'd1, 8'h80);
    mem[3] = enc(4'd4, 2'd0, 2'd0, 8'h00);
    exp_fetch(0, 8'h00, 8'h00); exp_fetch(3, 8'h01, 8'h00);
    exp_fetch(6, 8'h02, 8'h00); exp_fetch(9, 8'h03, 8'h08);
    release_reset();
    in_cycle(8);
    chk("add_out_c8", outputValue, 8'h00);
    chk("add_opcode", bus.opCode, 4'd2);
    chk("add_src1", bus.register1Value, 8'd5);
    chk("add_src2", bus.register2Value, 8'd3);
    in_cycle(9);  chk("add_out_c9", outputValue, 8'h08);
    in_cycle(11); chk("halt_c11", halted, 1'b0);
    in_cycle(12);
    chk("halt_c12", halted, 1'b1);
    chk("halt_pc", programCounter, 8'h03);
    chk("halt_rden", bus.programReadEnable, 1'b0);

    assert_reset();
    @(negedge clock);
    chk("rereset_pc", programCounter, 8'h00);
    chk("rereset_out", outputValue, 8'h00);
    chk("rereset_halted", halted, 1'b0);

    // DECREMENT r1 from 1 then JUMPZERO #0x20 -> taken
    mem[0] = enc(4'd0, 2'd1, 2'd0, 8'd1);
    mem[1] = enc(4'd14, 2'd1, 2'd1, 8'h00);
    mem[2] = enc(4'd3, 2'd0, 2'd0, 8'h20);
    exp_fetch(0, 8'h00, 8'h00); exp_fetch(3, 8'h01, 8'h00);
    exp_fetch(6, 8'h02, 8'h00); exp_fetch(9, 8'h20, 8'h00);
    release_reset();
    in_cycle(12);
    chk("jz_taken_halted", halted, 1'b1);
    chk("jz_taken_pc", programCounter, 8'h20);

    // Same from r1=2 -> not taken
    assert_reset();
    mem[0] = enc(4'd0, 2'd1, 2'd0, 8'd2);
    mem[1] = enc(4'd14, 2'd1, 2'd1, 8'h00);
    mem[2] = enc(4'd3, 2'd0, 2'd0, 8'h20);
    exp_fetch(0, 8'h00, 8'h00); exp_fetch(3, 8'h01, 8'h00);
    exp_fetch(6, 8'h02, 8'h00); exp_fetch(9, 8'h03, 8'h00);
    release_reset();
    in_cycle(12);
    chk("jz_fall_pc", programCounter, 8'h03);

    // PC wrap at 0xFF, INCREMENT r3,r3 from 0xFF sets zero flag
    assert_reset();
    mem[8'h00] = enc(4'd3, 2'd0, 2'd0, 8'h40);
    mem[8'h01] = enc(4'd0, 2'd3, 2'd0, 8'hFF);
    mem[8'h02] = enc(4'd1, 2'd0, 2'd0, 8'hFF);
    mem[8'hFF] = enc(4'd11, 2'd3, 2'd3, 8'h00);
    mem[8'h40] = enc(4'd11, 2'd0, 2'd3, 8'h00);
    exp_fetch(0, 8'h00, 8'h00);  exp_fetch(3, 8'h01, 8'h00);
    exp_fetch(6, 8'h02, 8'h00);  exp_fetch(9, 8'hFF, 8'h00);
    exp_fetch(12, 8'h00, 8'h00); exp_fetch(15, 8'h40, 8'h00);
    exp_fetch(18, 8'h41, 8'h01);
    release_reset();
    in_cycle(21);
    chk("wrap_halted", halted, 1'b1);
    chk("wrap_pc", programCounter, 8'h41);
    chk("wrap_out", outputValue, 8'h01);

    // hold in FETCH for 5 cycles, then hold raised during DECODE
    assert_reset();
    hold = 1'b1;
    mem[0] = enc(4'd0, 2'd0, 2'd0, 8'h12);
    mem[1] = enc(4'd0, 2'd0, 2'd0, 8'h34);
    exp_fetch(5, 8'h00, 8'h00); exp_fetch(10, 8'h01, 8'h12);
    exp_fetch(13, 8'h02, 8'h34);
    release_reset();
    for (int k = 0; k < 5; k++) begin
      in_cycle(k);
      chk("hold_rden", bus.programReadEnable, 1'b0);
      chk("hold_pc", programCounter, 8'h00);
    end
    start_cycle(5); hold = 1'b0;
    start_cycle(6); hold = 1'b1;
    in_cycle(8);
    chk("hold2_rden", bus.programReadEnable, 1'b0);
    chk("hold2_pc", programCounter, 8'h01);
    chk("hold2_out", outputValue, 8'h12);
    start_cycle(10); hold = 1'b0;
    start_cycle(16); hold = 1'b1;
    in_cycle(18);
    chk("halt_ignores_hold", halted, 1'b1);
    chk("halt_out", outputValue, 8'h34);
    hold = 1'b0;

    // reset during EXECUTE of LOAD0 r0,#0xAA discards the write
    assert_reset();
    mem[0] = enc(4'd0, 2'd0, 2'd0, 8'hAA);
    exp_fetch(0, 8'h00, 8'h00); exp_fetch(0, 8'h00, 8'h00);
    exp_fetch(3, 8'h01, 8'hAA);
    release_reset();
    start_cycle(2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_out", outputValue, 8'h00);
    chk("midreset_pc", programCounter, 8'h00);
    chk("midreset_fetch", bus.programReadEnable, 1'b1);
    in_cycle(6);
    chk("midreset_final_out", outputValue, 8'hAA);

    // NOP (opcode 9) at PC 4 leaves r0 alone
    assert_reset();
    mem[0] = enc(4'd0, 2'd0, 2'd0, 8'h77);
    mem[1] = enc(4'd1, 2'd0, 2'd0, 8'h04);
    mem[4] = enc(4'd9, 2'd0, 2'd0, 8'h00);
    exp_fetch(0, 8'h00, 8'h00); exp_fetch(3, 8'h01, 8'h77);
    exp_fetch(6, 8'h04, 8'h77); exp_fetch(9, 8'h05, 8'h77);
    release_reset();
    in_cycle(12);
    chk("nop_pc", programCounter, 8'h05);
    chk("nop_out", outputValue, 8'h77);

    // JUMP1 #4 at PC 4 loops, refetching every 3 cycles
    assert_reset();
    mem[0] = enc(4'd1, 2'd0, 2'd0, 8'h04);
    mem[4] = enc(4'd1, 2'd0, 2'd0, 8'h04);
    exp_fetch(0, 8'h00, 8'h00); exp_fetch(3, 8'h04, 8'h00);
    exp_fetch(6, 8'h04, 8'h00); exp_fetch(9, 8'h04, 8'h00);
    release_reset();
    in_cycle(8);
    chk("selfjump_pc", programCounter, 8'h04);
    chk("selfjump_halted", halted, 1'b0);
    start_cycle(10);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);

    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
